phy_tx_lanes: RTL and testbench

Parametrised single-clock transmit PHY: accepts DATA_W-bit words, stripes bytes round-robin over LANES serial lanes, and serializes each lane MSB-first at one bit per clock. It adds a link-training sequence (COM symbols until synced), IDL fill when no data is offered, a retrain request, and recirculation of words offered while the link is inactive. It replaces the multi-clock (f/2f/4f/32f) transmit path with one bit-rate clock plus internal word-period counting.

---
 rtl/phy_tx_lanes.sv | 110 +++++++++++
 tb/tb_phy_tx_lanes.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lanes.sv
// Single-clock striped transmit PHY: bytes go round-robin across LANES serial lanes,
// with COM training, IDL fill, retrain and capture of words offered while inactive.
module phy_tx_lanes #(
  parameter int         DATA_W     = 32,
  parameter int         LANES      = 2,
  parameter int         SYNC_WORDS = 4,
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter logic [7:0] IDL_BYTE   = 8'h7C
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid,
  input  logic              retrain,
  output logic              ready,
  output logic              active,
  output logic [LANES-1:0]  data_paralelo_serial,
  output logic [DATA_W-1:0] data_recirculador_inactive,
  output logic              recirc_valid
);
  localparam int BITS   = DATA_W / LANES;
  localparam int SLOTS  = BITS / 8;
  localparam int CNT_W  = $clog2(BITS);
  localparam int SYNC_W = $clog2(SYNC_WORDS + 1);

  typedef enum logic [1:0] {SRC_COM, SRC_IDL, SRC_DATA} src_t;

  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [SYNC_W-1:0] sync_cnt_reg, sync_cnt_next;
  logic              active_reg, active_next;
  logic [DATA_W-1:0] recirc_data_reg;
  logic              recirc_valid_reg;
  logic [BITS-1:0]   shift_reg [LANES];
  logic [BITS-1:0]   load_word [LANES];
  logic [BITS-1:0]   data_lane [LANES];
  logic              load_edge;
  logic [7:0]        fill_byte;
  src_t              src;

  assign load_edge    = (bit_cnt_reg == CNT_W'(BITS - 1));
  assign bit_cnt_next = load_edge ? '0 : bit_cnt_reg + 1'b1;

  // Link control and load-source selection; only committed on load edges.
  always_comb begin
    src           = SRC_COM;
    active_next   = active_reg;
    sync_cnt_next = sync_cnt_reg;
    if (!active_reg) begin
      if (sync_cnt_reg == SYNC_W'(SYNC_WORDS)) begin
        active_next = 1'b1;
        src         = SRC_IDL;
      end else begin
        sync_cnt_next = sync_cnt_reg + 1'b1;
      end
    end else if (retrain) begin
      active_next   = 1'b0;
      sync_cnt_next = '0;
    end else if (valid) begin
      src = SRC_DATA;
    end else begin
      src = SRC_IDL;
    end
  end

  assign fill_byte = (src == SRC_COM) ? COM_BYTE : IDL_BYTE;

  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Byte k lands on lane k mod LANES, slot k div LANES; slot 0 is shifted out first.
      for (gj = 0; gj < SLOTS; gj++) begin : g_slot
        assign data_lane[gi][BITS-1-8*gj -: 8] = data_input[DATA_W-1-8*(gj*LANES+gi) -: 8];
      end
      assign load_word[gi]            = (src == SRC_DATA) ? data_lane[gi] : {SLOTS{fill_byte}};
      assign data_paralelo_serial[gi] = shift_reg[gi][BITS-1];
    end
  endgenerate

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg      <= '0;
      sync_cnt_reg     <= '0;
      active_reg       <= 1'b0;
      recirc_data_reg  <= '0;
      recirc_valid_reg <= 1'b0;
      for (int l = 0; l < LANES; l++) shift_reg[l] <= '0;
    end else begin
      bit_cnt_reg      <= bit_cnt_next;
      recirc_valid_reg <= 1'b0;
      if (load_edge) begin
        active_reg   <= active_next;
        sync_cnt_reg <= sync_cnt_next;
        if (!active_reg && valid) begin
          recirc_data_reg  <= data_input;
          recirc_valid_reg <= 1'b1;
        end
      end
      for (int l = 0; l < LANES; l++) begin
        shift_reg[l] <= load_edge ? load_word[l] : {shift_reg[l][BITS-2:0], 1'b0};
      end
    end
  end

  // A retrain request wins over acceptance, so ready is withheld on that edge.
  assign ready                      = active_reg && load_edge && !retrain;
  assign active                     = active_reg;
  assign data_recirculador_inactive = recirc_data_reg;
  assign recirc_valid               = recirc_valid_reg;

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Self-checking bench for phy_tx_lanes (DATA_W=32, LANES=2, SYNC_WORDS=4) against
// a word-period reference model of the striped serial stream.
module tb_phy_tx_lanes;
  localparam int DATA_W      = 32;
  localparam int LANES       = 2;
  localparam int SYNC_WORDS  = 4;
  localparam int BITS        = DATA_W / LANES;
  localparam int NBYTES      = DATA_W / 8;
  localparam int TRAIN_EDGES = (SYNC_WORDS + 1) * BITS;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_input = '0;
  logic              valid = 1'b0;
  logic              retrain = 1'b0;
  logic              ready;
  logic              active;
  logic [LANES-1:0]  data_paralelo_serial;
  logic [DATA_W-1:0] data_recirculador_inactive;
  logic              recirc_valid;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phy_tx_lanes #(
    .DATA_W(DATA_W), .LANES(LANES), .SYNC_WORDS(SYNC_WORDS),
    .COM_BYTE(COM), .IDL_BYTE(IDL)
  ) dut (
    .clk_32f(clk), .reset(rst_n), .data_input(data_input), .valid(valid),
    .retrain(retrain), .ready(ready), .active(active),
    .data_paralelo_serial(data_paralelo_serial),
    .data_recirculador_inactive(data_recirculador_inactive),
    .recirc_valid(recirc_valid)
  );

  // Reference model: edges since reset, and the bytes of the word period in flight.
  int                m_edges = 0;
  int                m_sync = 0;
  bit                m_active = 1'b0;
  bit                m_loaded = 1'b0;
  bit                m_rv = 1'b0;
  logic [DATA_W-1:0] m_recirc = '0;
  logic [7:0]        m_bytes [NBYTES];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0; m_sync <= 0; m_active <= 1'b0; m_loaded <= 1'b0;
      m_rv <= 1'b0; m_recirc <= '0;
      for (int k = 0; k < NBYTES; k++) m_bytes[k] <= 8'h00;
    end else begin
      m_edges <= m_edges + 1;
      m_rv    <= 1'b0;
      if ((m_edges + 1) % BITS == 0) begin
        m_loaded <= 1'b1;
        if (!m_active && valid) begin
          m_recirc <= data_input;
          m_rv     <= 1'b1;
        end
        if (!m_active && m_sync < SYNC_WORDS) begin
          m_sync <= m_sync + 1;
          for (int k = 0; k < NBYTES; k++) m_bytes[k] <= COM;
        end else if (!m_active) begin
          m_active <= 1'b1;
          for (int k = 0; k < NBYTES; k++) m_bytes[k] <= IDL;
        end else if (retrain) begin
          m_active <= 1'b0;
          m_sync   <= 0;
          for (int k = 0; k < NBYTES; k++) m_bytes[k] <= COM;
        end else if (valid) begin
          for (int k = 0; k < NBYTES; k++) m_bytes[k] <= data_input[DATA_W-1-8*k -: 8];
        end else begin
          for (int k = 0; k < NBYTES; k++) m_bytes[k] <= IDL;
        end
      end
    end
  end

  function automatic logic [LANES-1:0] exp_serial();
    logic [LANES-1:0] r = '0;
    int p = m_edges % BITS;
    if (m_loaded)
      for (int l = 0; l < LANES; l++) r[l] = m_bytes[(p / 8) * LANES + l][7 - (p % 8)];
    return r;
  endfunction

  function automatic logic exp_ready();
    return m_active && ((m_edges + 1) % BITS == 0) && !retrain;
  endfunction

  task automatic wait_pre_load();
    do @(negedge clk); while (((m_edges + 1) % BITS) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; retrain = 1'b0; data_input = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (data_paralelo_serial !== '0) begin n_fail++; $display("FAIL reset_serial got=%b exp=0", data_paralelo_serial); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
    if (recirc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", recirc_valid); end
    if (data_recirculador_inactive !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", data_recirculador_inactive); end
    rst_n = 1'b1;
    $display("reset: outputs checked while held");
  endtask

  task automatic test_training();
    int rise = -1;
    for (int i = 1; i <= TRAIN_EDGES + 2 * BITS; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (data_paralelo_serial !== exp_serial()) begin n_fail++; $display("FAIL train_serial edge=%0d got=%b exp=%b", i, data_paralelo_serial, exp_serial()); end
      if (active !== m_active) begin n_fail++; $display("FAIL train_active edge=%0d got=%b exp=%b", i, active, m_active); end
      if (ready !== exp_ready()) begin n_fail++; $display("FAIL train_ready edge=%0d got=%b exp=%b", i, ready, exp_ready()); end
      if (active === 1'b1 && rise < 0) rise = i;
    end
    n_cmp++;
    if (rise != TRAIN_EDGES) begin n_fail++; $display("FAIL train_rise_edge got=%0d exp=%0d", rise, TRAIN_EDGES); end
    $display("training: active rose at edge %0d", rise);
  endtask

  task automatic test_recirc();
    int pulses = 0;
    do_reset();
    valid = 1'b1; data_input = 32'hDEADBEEF;
    for (int i = 1; i <= TRAIN_EDGES; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (recirc_valid !== m_rv) begin n_fail++; $display("FAIL recirc_valid edge=%0d got=%b exp=%b", i, recirc_valid, m_rv); end
      if (data_recirculador_inactive !== m_recirc) begin n_fail++; $display("FAIL recirc_data edge=%0d got=%h exp=%h", i, data_recirculador_inactive, m_recirc); end
      if (data_paralelo_serial !== exp_serial()) begin n_fail++; $display("FAIL recirc_serial edge=%0d got=%b exp=%b", i, data_paralelo_serial, exp_serial()); end
      if (recirc_valid === 1'b1) pulses++;
    end
    valid = 1'b0;
    n_cmp += 2;
    if (data_recirculador_inactive !== 32'hDEADBEEF) begin n_fail++; $display("FAIL recirc_final got=%h exp=deadbeef", data_recirculador_inactive); end
    if (pulses != SYNC_WORDS + 1) begin n_fail++; $display("FAIL recirc_pulses got=%0d exp=%0d", pulses, SYNC_WORDS + 1); end
    $display("recirc: %0d pulses, data=%h", pulses, data_recirculador_inactive);
  endtask

  task automatic test_back_to_back();
    logic [31:0] l0 = '0;
    logic [31:0] l1 = '0;
    wait_pre_load();
    data_input = 32'hA1B2C3D4; valid = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    for (int i = 0; i < 2 * BITS; i++) begin
      @(negedge clk);
      l0 = {l0[30:0], data_paralelo_serial[0]};
      l1 = {l1[30:0], data_paralelo_serial[1]};
      if (i == BITS - 1) data_input = 32'h01234567;
      if (i == 2 * BITS - 1) valid = 1'b0;
    end
    n_cmp += 2;
    if (l0 !== 32'hA1C30145) begin n_fail++; $display("FAIL b2b_lane0 got=%h exp=a1c30145", l0); end
    if (l1 !== 32'hB2D42367) begin n_fail++; $display("FAIL b2b_lane1 got=%h exp=b2d42367", l1); end
    $display("back_to_back: lane0=%h lane1=%h", l0, l1);
  endtask

  task automatic test_retrain();
    int rise = -1;
    wait_pre_load();
    retrain = 1'b1; valid = 1'b1; data_input = $urandom;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL retrain_ready got=%b exp=0", ready); end
    @(negedge clk);
    retrain = 1'b0; valid = 1'b0;
    n_cmp++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL retrain_drop got=%b exp=0", active); end
    for (int i = 1; i <= 2 * TRAIN_EDGES; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (data_paralelo_serial !== exp_serial()) begin n_fail++; $display("FAIL retrain_serial i=%0d got=%b exp=%b", i, data_paralelo_serial, exp_serial()); end
      if (active !== m_active) begin n_fail++; $display("FAIL retrain_active i=%0d got=%b exp=%b", i, active, m_active); end
      if (active === 1'b1 && rise < 0) rise = i;
    end
    n_cmp++;
    if (rise != TRAIN_EDGES) begin n_fail++; $display("FAIL retrain_rise got=%0d exp=%0d", rise, TRAIN_EDGES); end
    $display("retrain: active back after %0d edges", rise);
  endtask

  task automatic test_random();
    for (int c = 0; c < 40 * BITS; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (data_paralelo_serial !== exp_serial()) begin n_fail++; $display("FAIL rand_serial c=%0d got=%b exp=%b", c, data_paralelo_serial, exp_serial()); end
      if (active !== m_active) begin n_fail++; $display("FAIL rand_active c=%0d got=%b exp=%b", c, active, m_active); end
      if (recirc_valid !== m_rv) begin n_fail++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, recirc_valid, m_rv); end
      if (data_recirculador_inactive !== m_recirc) begin n_fail++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, data_recirculador_inactive, m_recirc); end
      data_input = $urandom;
      valid      = ($urandom_range(0, 3) != 0);
      retrain    = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp++;
      if (ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ready, exp_ready()); end
    end
    valid = 1'b0; retrain = 1'b0;
    $display("random: %0d cycles of mixed traffic", 40 * BITS);
  endtask

  task automatic test_reset_mid_word();
    int rise = -1;
    do_reset();
    repeat (TRAIN_EDGES) @(negedge clk);
    wait_pre_load();
    valid = 1'b1; data_input = $urandom;
    @(negedge clk);
    valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (data_paralelo_serial !== '0) begin n_fail++; $display("FAIL mid_serial got=%b exp=0", data_paralelo_serial); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL mid_active got=%b exp=0", active); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", ready); end
    if (data_recirculador_inactive !== '0) begin n_fail++; $display("FAIL mid_rdata got=%h exp=0", data_recirculador_inactive); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= TRAIN_EDGES + BITS; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (data_paralelo_serial !== exp_serial()) begin n_fail++; $display("FAIL mid_train_serial edge=%0d got=%b exp=%b", i, data_paralelo_serial, exp_serial()); end
      if (active !== m_active) begin n_fail++; $display("FAIL mid_train_active edge=%0d got=%b exp=%b", i, active, m_active); end
      if (active === 1'b1 && rise < 0) rise = i;
    end
    n_cmp++;
    if (rise != TRAIN_EDGES) begin n_fail++; $display("FAIL mid_rise got=%0d exp=%0d", rise, TRAIN_EDGES); end
    $display("reset_mid_word: retrained, active at edge %0d", rise);
  endtask

  initial begin
    test_reset();
    test_training();
    test_back_to_back();
    test_retrain();
    test_recirc();
    test_random();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
